tx_serial_arbitro_rr: RTL

//  Round-robin arbiter/sequencer sharing one 7O1 serial transmitter among N_REQ requesters.

---
 rtl/tx_serial_arbitro_rr_if.sv | 27 ++
 rtl/tx_serial_arbitro_rr.sv | 121 ++++++++++++
 2 files changed

// File: rtl/tx_serial_arbitro_rr_if.sv
// Bundle between requesters/transmitter (master side) and the round-robin arbiter (slave side).
// Signal names follow the transmitter's own naming so the wiring reads one-to-one.
interface tx_serial_arbitro_rr_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [7*N_REQ-1:0] dados_req;
    logic               tx_pronto;
    logic               tx_partida;
    logic [6:0]         tx_dados;
    logic [N_REQ-1:0]   grant;
    logic [N_REQ-1:0]   ack;
    logic               erro;
    logic               ocupado;
    logic [3:0]         db_estado;
    logic [7:0]         db_total;

    modport master (
        output req, dados_req, tx_pronto,
        input  tx_partida, tx_dados, grant, ack, erro, ocupado, db_estado, db_total
    );

    modport slave (
        input  req, dados_req, tx_pronto,
        output tx_partida, tx_dados, grant, ack, erro, ocupado, db_estado, db_total
    );
endinterface

// File: rtl/tx_serial_arbitro_rr.sv
// Round-robin sequencer sharing one 7O1 serial transmitter among N_REQ requesters,
// with a watchdog that abandons a frame whose tx_pronto never arrives.
module tx_serial_arbitro_rr #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 65536
) (
    input logic                   clock,
    input logic                   reset,
    tx_serial_arbitro_rr_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        PARTIDA = 2'd1,
        ESPERA  = 2'd2,
        CONCLUI = 2'd3
    } estado_t;

    estado_t            estado_q;
    logic [IDX_W-1:0]   ponteiro_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WD_W-1:0]    watchdog_q;
    logic [6:0]         tx_dados_q;
    logic [N_REQ-1:0]   grant_q;
    logic [N_REQ-1:0]   ack_q;
    logic               erro_q;
    logic               tx_partida_q;
    logic [7:0]         db_total_q;

    logic [6:0]         chars [N_REQ];
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_ok;

    for (genvar g = 0; g < N_REQ; g++) begin : g_chars
        assign chars[g] = bus.dados_req[7*g +: 7];
    end

    // Scan starts at the pointer and wraps, so the last winner is checked last.
    always_comb begin
        int               s;
        logic [IDX_W-1:0] cand;
        // NOTE: every always_comb output gets a default up front so no path infers a latch.
        s        = 0;
        cand     = '0;
        pick_ok  = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            s = int'(ponteiro_q) + k;
            if (s >= N_REQ) s = s - N_REQ;
            cand = IDX_W'(s);
            if (!pick_ok && bus.req[cand]) begin
                pick_ok  = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q     <= OCIOSO;
            ponteiro_q   <= '0;
            idx_q        <= '0;
            watchdog_q   <= '0;
            tx_dados_q   <= '0;
            grant_q      <= '0;
            ack_q        <= '0;
            erro_q       <= 1'b0;
            tx_partida_q <= 1'b0;
            db_total_q   <= '0;
        end else begin
            tx_partida_q <= 1'b0;
            ack_q        <= '0;
            erro_q       <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (pick_ok) begin
                        estado_q     <= PARTIDA;
                        idx_q        <= pick_idx;
                        grant_q      <= N_REQ'(1) << pick_idx;
                        tx_dados_q   <= chars[pick_idx];
                        tx_partida_q <= 1'b1;
                    end
                end
                PARTIDA: begin
                    watchdog_q <= '0;
                    estado_q   <= ESPERA;
                end
                ESPERA: begin
                    watchdog_q <= watchdog_q + WD_W'(1);
                    if (bus.tx_pronto) begin
                        estado_q   <= CONCLUI;
                        ack_q      <= grant_q;
                        db_total_q <= db_total_q + 8'd1;
                    end else if (watchdog_q == WD_LAST) begin
                        estado_q <= CONCLUI;
                        erro_q   <= 1'b1;
                    end
                end
                CONCLUI: begin
                    ponteiro_q <= (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
                    grant_q    <= '0;
                    estado_q   <= OCIOSO;
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign bus.tx_partida = tx_partida_q;
    assign bus.tx_dados   = tx_dados_q;
    assign bus.grant      = grant_q;
    assign bus.ack        = ack_q;
    assign bus.erro       = erro_q;
    assign bus.ocupado    = (estado_q != OCIOSO);
    assign bus.db_estado  = {2'b00, estado_q};
    assign bus.db_total   = db_total_q;
endmodule
